// File: rtl/echo_pkg.sv
// Shared definitions for the echo-cancellation pipeline and its observers.
// Holds datapath widths, the residual monitor FSM state type and small
// arithmetic helpers used by more than one module.
package echo_pkg;

    localparam int SIG_W        = 16;   // residual sample width
    localparam int CNT_W        = 13;   // sampling phase counter width
    localparam int ENERGY_W     = 32;   // width of a square / mean energy
    localparam int MAX_LOG2_WIN = 8;    // largest supported log2(window length)
    localparam int HOLD_CNT_W   = 8;    // below-threshold run counter width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPORT = 2'd2
    } mon_state_e;

    // Magnitude of a signed sample as an unsigned value; the most negative
    // code maps to 2^(SIG_W-1), which still fits the unsigned range.
    function automatic logic [SIG_W-1:0] abs_sig(input logic signed [SIG_W-1:0] x);
        logic [SIG_W-1:0] r;
        if (x[SIG_W-1]) begin
            r = (~x) + {{(SIG_W-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [HOLD_CNT_W-1:0] sat_inc_hold(input logic [HOLD_CNT_W-1:0] v);
        logic [HOLD_CNT_W-1:0] r;
        if (v == {HOLD_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/residual_square_abs.sv
// One registered stage computing the square and magnitude of a signed sample.
// Ports:
//   clk_operation  - rising-edge clock
//   rst            - synchronous active-high reset
//   flush          - drops any result currently held (partial window discard)
//   sample_valid   - qualifies sample for capture this cycle
//   sample         - signed residual sample
//   square_valid   - result below is valid (one cycle after sample_valid)
//   square         - sample*sample as unsigned (max 2^30, never saturates)
//   magnitude      - |sample| as unsigned (max 2^15)
module residual_square_abs
    import echo_pkg::*;
(
    input  logic                       clk_operation,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       sample_valid,
    input  logic signed [SIG_W-1:0]    sample,
    output logic                       square_valid,
    output logic [ENERGY_W-1:0]        square,
    output logic [SIG_W-1:0]           magnitude
);

    logic signed [ENERGY_W-1:0] prod_s;
    logic                       valid_r;
    logic [ENERGY_W-1:0]        square_r;
    logic [SIG_W-1:0]           magnitude_r;

    // Signed full-width product; the only positive overflow candidate
    // (-32768)^2 = 2^30 fits comfortably in 32 bits.
    always_comb begin
        prod_s = sample * sample;
    end

    // Capture stage; flush wins over a new sample so a discarded window
    // leaves nothing behind.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            valid_r     <= 1'b0;
            square_r    <= {ENERGY_W{1'b0}};
            magnitude_r <= {SIG_W{1'b0}};
        end else if (flush) begin
            valid_r     <= 1'b0;
        end else begin
            valid_r <= sample_valid;
            if (sample_valid) begin
                square_r    <= unsigned'(prod_s);
                magnitude_r <= abs_sig(sample);
            end
        end
    end

    assign square_valid = valid_r;
    assign square       = square_r;
    assign magnitude    = magnitude_r;

endmodule

// File: rtl/residual_energy_monitor.sv
// Observes the echo canceller residual: squares one sample per sampling
// period, averages the squares over 2^LOG2_WIN samples, reports mean energy
// and peak magnitude per window, and flags convergence after HOLD_WINDOWS
// consecutive windows with energy strictly below thresh.
// Ports:
//   clk_operation          - rising-edge clock
//   rst                    - synchronous active-high reset
//   enable                 - run level; low discards the partial window
//   sampling_cycle_counter - shared phase counter, sample taken at SAMPLE_PHASE
//   sig16b_without_echo    - signed residual sample
//   thresh                 - unsigned energy threshold
//   energy                 - mean square of last complete window
//   peak_abs               - max |sample| of last complete window
//   energy_valid           - one-cycle pulse on each window report
//   converged              - below-threshold run has reached HOLD_WINDOWS
//   windows_done           - saturating count of completed windows
module residual_energy_monitor
    import echo_pkg::*;
#(
    parameter int               LOG2_WIN     = 4,
    parameter logic [CNT_W-1:0] SAMPLE_PHASE = 13'd3999,
    parameter int               HOLD_WINDOWS = 4
) (
    input  logic                  clk_operation,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      sampling_cycle_counter,
    input  logic [SIG_W-1:0]      sig16b_without_echo,
    input  logic [ENERGY_W-1:0]   thresh,
    output logic [ENERGY_W-1:0]   energy,
    output logic [SIG_W-1:0]      peak_abs,
    output logic                  energy_valid,
    output logic                  converged,
    output logic [15:0]           windows_done
);

    localparam int                    ACC_W     = ENERGY_W + LOG2_WIN;
    localparam int                    WCNT_W    = LOG2_WIN + 1;
    localparam int                    WIN       = 1 << LOG2_WIN;
    localparam logic [WCNT_W-1:0]     LAST_IDX  = WCNT_W'(WIN - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_THR  = HOLD_CNT_W'(HOLD_WINDOWS);

    mon_state_e              state_r;
    mon_state_e              state_nxt_s;

    logic                    strobe_s;
    logic                    flush_s;
    logic                    sq_valid_s;
    logic [ENERGY_W-1:0]     sq_s;
    logic [SIG_W-1:0]        mag_s;

    logic [ACC_W-1:0]        acc_r;
    logic [WCNT_W-1:0]       cnt_r;
    logic [SIG_W-1:0]        peak_r;

    logic [ACC_W-1:0]        acc_sum_s;
    logic [SIG_W-1:0]        peak_nxt_s;
    logic                    accept_s;
    logic                    window_done_s;
    logic [ENERGY_W-1:0]     new_energy_s;
    logic [HOLD_CNT_W-1:0]   hold_nxt_s;

    logic [ENERGY_W-1:0]     energy_r;
    logic [SIG_W-1:0]        peak_abs_r;
    logic                    energy_valid_r;
    logic                    converged_r;
    logic [15:0]             windows_done_r;
    logic [HOLD_CNT_W-1:0]   hold_cnt_r;

    // Strobe and discard qualifiers.
    always_comb begin
        strobe_s = enable && (sampling_cycle_counter == SAMPLE_PHASE);
        flush_s  = (state_r == FILL) && !enable;
    end

    residual_square_abs u_s1 (
        .clk_operation (clk_operation),
        .rst           (rst),
        .flush         (flush_s),
        .sample_valid  (strobe_s),
        .sample        ($signed(sig16b_without_echo)),
        .square_valid  (sq_valid_s),
        .square        (sq_s),
        .magnitude     (mag_s)
    );

    // S2 arithmetic: the window sum and running peak including the square
    // arriving this cycle, and the report values derived from them. Outputs
    // are loaded on the edge that enters REPORT so they are visible during it.
    always_comb begin
        acc_sum_s     = acc_r + ACC_W'(sq_s);
        peak_nxt_s    = (mag_s > peak_r) ? mag_s : peak_r;
        accept_s      = (state_r == FILL) && enable && sq_valid_s;
        window_done_s = accept_s && (cnt_r == LAST_IDX);
        new_energy_s  = ENERGY_W'(acc_sum_s >> LOG2_WIN);
        if (new_energy_s < thresh) begin
            hold_nxt_s = sat_inc_hold(hold_cnt_r);
        end else begin
            hold_nxt_s = {HOLD_CNT_W{1'b0}};
        end
    end

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FILL: begin
                if (!enable) begin
                    state_nxt_s = IDLE;
                end else if (window_done_s) begin
                    state_nxt_s = REPORT;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            REPORT: begin
                if (enable) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Window accumulator, sample count and running peak.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            acc_r  <= {ACC_W{1'b0}};
            cnt_r  <= {WCNT_W{1'b0}};
            peak_r <= {SIG_W{1'b0}};
        end else begin
            case (state_r)
                FILL: begin
                    if (!enable) begin
                        acc_r  <= {ACC_W{1'b0}};
                        cnt_r  <= {WCNT_W{1'b0}};
                        peak_r <= {SIG_W{1'b0}};
                    end else if (accept_s) begin
                        // The full sum stays visible through REPORT, then clears.
                        acc_r  <= acc_sum_s;
                        peak_r <= peak_nxt_s;
                        if (window_done_s) begin
                            cnt_r <= {WCNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        acc_r  <= acc_r;
                    end
                end
                default: begin
                    // IDLE and REPORT both start the next window from zero.
                    acc_r  <= {ACC_W{1'b0}};
                    cnt_r  <= {WCNT_W{1'b0}};
                    peak_r <= {SIG_W{1'b0}};
                end
            endcase
        end
    end

    // Report outputs and convergence tracking; all hold outside a report.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            energy_r       <= {ENERGY_W{1'b0}};
            peak_abs_r     <= {SIG_W{1'b0}};
            energy_valid_r <= 1'b0;
            converged_r    <= 1'b0;
            windows_done_r <= 16'd0;
            hold_cnt_r     <= {HOLD_CNT_W{1'b0}};
        end else begin
            energy_valid_r <= window_done_s;
            if (window_done_s) begin
                energy_r    <= new_energy_s;
                peak_abs_r  <= peak_nxt_s;
                hold_cnt_r  <= hold_nxt_s;
                converged_r <= (hold_nxt_s >= HOLD_THR);
                if (windows_done_r != 16'hFFFF) begin
                    windows_done_r <= windows_done_r + 16'd1;
                end
            end
        end
    end

    assign energy       = energy_r;
    assign peak_abs     = peak_abs_r;
    assign energy_valid = energy_valid_r;
    assign converged    = converged_r;
    assign windows_done = windows_done_r;

endmodule

// File: tb/tb_residual_energy_monitor.sv
// Self-checking bench for residual_energy_monitor: table-driven constant
// windows, hand-written convergence / enable / reset sequences, and a
// randomized phase checked against a window-level reference model.
module tb_residual_energy_monitor;

    localparam int          LOG2_WIN = 4;
    localparam int          WIN      = 16;
    localparam int          HOLD     = 4;
    localparam logic [12:0] PHASE    = 13'd3999;

    logic        clk_operation = 1'b0;
    logic        rst;
    logic        enable;
    logic [12:0] sampling_cycle_counter;
    logic [15:0] sig16b_without_echo;
    logic [31:0] thresh;
    logic [31:0] energy;
    logic [15:0] peak_abs;
    logic        energy_valid;
    logic        converged;
    logic [15:0] windows_done;

    always #5 clk_operation = ~clk_operation;

    residual_energy_monitor #(
        .LOG2_WIN     (LOG2_WIN),
        .SAMPLE_PHASE (PHASE),
        .HOLD_WINDOWS (HOLD)
    ) dut (
        .clk_operation          (clk_operation),
        .rst                    (rst),
        .enable                 (enable),
        .sampling_cycle_counter (sampling_cycle_counter),
        .sig16b_without_echo    (sig16b_without_echo),
        .thresh                 (thresh),
        .energy                 (energy),
        .peak_abs               (peak_abs),
        .energy_valid           (energy_valid),
        .converged              (converged),
        .windows_done           (windows_done)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model: samples of the open window and last reported values.
    int     q[$];
    longint e_m;
    int     p_m;
    int     hc_m;
    int     wd_m;
    bit     conv_m;

    typedef struct {
        int          value;
        logic [31:0] thr;
        longint      exp_energy;
        int          exp_peak;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_operation);
        #1;
        if (energy_valid) pulses++;
    endtask

    task automatic model_reset();
        q.delete();
        e_m = 0; p_m = 0; hc_m = 0; wd_m = 0; conv_m = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_energy"},    energy,       e_m);
        chk({tag, "_peak"},      peak_abs,     p_m);
        chk({tag, "_converged"}, converged,    conv_m);
        chk({tag, "_windows"},   windows_done, wd_m);
    endtask

    // One sampling period: strobe cycle t, then three quiet cycles.
    task automatic strobe(input int s);
        bit     done;
        longint sum;
        int     pk;
        int     a;
        sig16b_without_echo    = 16'(s);
        sampling_cycle_counter = PHASE;
        step();
        sampling_cycle_counter = 13'($urandom_range(0, 3998));
        sig16b_without_echo    = 16'($urandom);
        step();
        q.push_back(s);
        done = 1'b0;
        if (q.size() == WIN) begin
            sum = 0;
            pk  = 0;
            foreach (q[i]) begin
                sum += longint'(q[i]) * longint'(q[i]);
                a = (q[i] < 0) ? -q[i] : q[i];
                if (a > pk) pk = a;
            end
            e_m = sum / WIN;
            p_m = pk;
            if (wd_m < 65535) wd_m++;
            if (e_m < longint'(thresh)) begin
                if (hc_m < 255) hc_m++;
            end else begin
                hc_m = 0;
            end
            conv_m = (hc_m >= HOLD);
            q.delete();
            done = 1'b1;
        end
        chk("valid_at_t2", energy_valid, done);
        check_outputs("t2");
        step();
        chk("valid_at_t3", energy_valid, 0);
        step();
    endtask

    task automatic drop_enable(input int cycles);
        enable = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            chk("valid_in_gap", energy_valid, 0);
        end
        q.delete();
        check_outputs("gap");
        enable = 1'b1;
        step();
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        enable = 1'b0;
        sampling_cycle_counter = 13'd0;
        sig16b_without_echo = 16'd0;
        thresh = 32'd0;
        model_reset();
        step();
        step();
        chk("rst_energy", energy, 0);
        chk("rst_peak", peak_abs, 0);
        chk("rst_valid", energy_valid, 0);
        chk("rst_converged", converged, 0);
        chk("rst_windows", windows_done, 0);
        rst = 1'b0;
        enable = 1'b1;
        step();

        // Constant-value windows with hand-computed results.
        tbl[0] = '{value: 100,    thr: 32'd0, exp_energy: 64'd10000,      exp_peak: 100};
        tbl[1] = '{value: -32768, thr: 32'd0, exp_energy: 64'd1073741824, exp_peak: 32768};
        tbl[2] = '{value: 32767,  thr: 32'd0, exp_energy: 64'd1073676289, exp_peak: 32767};
        tbl[3] = '{value: 10,     thr: 32'd0, exp_energy: 64'd100,        exp_peak: 10};
        for (int v = 0; v < 4; v++) begin
            thresh = tbl[v].thr;
            p0 = pulses;
            for (int k = 0; k < WIN; k++) strobe(tbl[v].value);
            chk("tbl_pulses", pulses - p0, 1);
            chk("tbl_energy", energy, tbl[v].exp_energy);
            chk("tbl_peak", peak_abs, tbl[v].exp_peak);
            chk("tbl_windows", windows_done, v + 1);
        end

        // Alternating +3/-4: (8*9+8*16)/16 = 12.5 truncates to 12.
        for (int k = 0; k < WIN; k++) strobe((k % 2 == 0) ? 3 : -4);
        chk("alt_energy", energy, 12);
        chk("alt_peak", peak_abs, 4);

        // Convergence rises on window 4 of zeros, falls on a window of 10s.
        thresh = 32'd50;
        for (int w = 1; w <= 5; w++) begin
            for (int k = 0; k < WIN; k++) strobe(0);
            chk("conv_zero_win", converged, (w >= 4) ? 1 : 0);
        end
        for (int k = 0; k < WIN - 1; k++) strobe(10);
        chk("conv_before_fail", converged, 1);
        strobe(10);
        chk("conv_after_fail", converged, 0);
        chk("conv_fail_energy", energy, 100);

        // Enable dropped after 7 strobes: partial window discarded.
        thresh = 32'd0;
        for (int k = 0; k < 7; k++) strobe(7);
        drop_enable(5);
        chk("gap_energy_held", energy, 100);
        p0 = pulses;
        for (int k = 0; k < WIN; k++) strobe(2);
        chk("en_pulses", pulses - p0, 1);
        chk("en_energy", energy, 4);
        chk("en_peak", peak_abs, 2);

        // Reset mid-window while converged.
        thresh = 32'd50;
        for (int w = 0; w < 4; w++) for (int k = 0; k < WIN; k++) strobe(0);
        chk("pre_rst_converged", converged, 1);
        for (int k = 0; k < 9; k++) strobe(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("mid_rst_energy", energy, 0);
        chk("mid_rst_peak", peak_abs, 0);
        chk("mid_rst_valid", energy_valid, 0);
        chk("mid_rst_converged", converged, 0);
        chk("mid_rst_windows", windows_done, 0);
        step();
        p0 = pulses;
        for (int k = 0; k < WIN - 1; k++) strobe(1);
        chk("post_rst_15", pulses - p0, 0);
        strobe(1);
        chk("post_rst_16", pulses - p0, 1);
        chk("post_rst_energy", energy, 1);

        // Randomized phase against the reference model.
        for (int n = 0; n < 160; n++) begin
            if ((n % WIN) == 0) thresh = $urandom_range(0, 32'h4000_0000);
            if ($urandom_range(0, 15) == 0) drop_enable($urandom_range(1, 4));
            strobe(int'($signed(16'($urandom))));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                sampling_cycle_counter = 13'($urandom_range(0, 3998));
                step();
                chk("valid_idle_gap", energy_valid, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
